sata_fis_rx_router: RTL

// - Transport-layer RX stage between link-layer frame output and the per-type FIS receivers.
// - Decodes FIS type (word 0, bits [7:0]) on the first word of each frame and routes the whole frame:
//   - Register-class FIS go to the register-FIS receiver path.
//   - Data FIS go to the data path (with backpressure).
//   - DMA Activate produces a pulse.
//   - Unknown frames are dropped and flagged.
// - One registered stage; the frame word stream is passed through unmodified.

---
 rtl/sata_fis_pkg.sv | 49 ++++
 rtl/sata_fis_rx_router_len_checker.sv | 49 ++++
 rtl/sata_fis_rx_router.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sata_fis_pkg.sv
// FIS type codes, routing enum and per-type length table for the SATA transport RX path.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package sata_fis_pkg;

    localparam logic [7:0] FIS_REG_D2H   = 8'h34;
    localparam logic [7:0] FIS_PIO_SETUP = 8'h5F;
    localparam logic [7:0] FIS_SDB       = 8'hA1;
    localparam logic [7:0] FIS_DMA_SETUP = 8'h41;
    localparam logic [7:0] FIS_DMA_ACT   = 8'h39;
    localparam logic [7:0] FIS_DATA      = 8'h46;

    typedef enum logic [2:0] {
        RT_IDLE,
        RT_REG,
        RT_DATA,
        RT_DMAA,
        RT_DROP
    } route_t;

    // Destination for a frame whose header type byte is t.
    function automatic route_t fis_route(input logic [7:0] t);
        route_t r;
        case (t)
            FIS_REG_D2H, FIS_PIO_SETUP, FIS_SDB, FIS_DMA_SETUP: r = RT_REG;
            FIS_DATA:                                           r = RT_DATA;
            FIS_DMA_ACT:                                        r = RT_DMAA;
            default:                                            r = RT_DROP;
        endcase
        return r;
    endfunction

    // Expected frame length in words. For Data FIS this is the minimum
    // length (header + at least one payload word). 0 means "not checked".
    function automatic logic [3:0] fis_len(input logic [7:0] t);
        logic [3:0] n;
        case (t)
            FIS_REG_D2H:   n = 4'd5;
            FIS_PIO_SETUP: n = 4'd5;
            FIS_SDB:       n = 4'd2;
            FIS_DMA_SETUP: n = 4'd7;
            FIS_DMA_ACT:   n = 4'd1;
            FIS_DATA:      n = 4'd2;
            default:       n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sata_fis_rx_router_len_checker.sv
// Per-frame word counter compared against the FIS type's expected length at eop.
// Latency: combinational mismatch flag in the eop transfer cycle; counter updates on each transfer.
// Backpressure: none of its own; counts only accepted transfers (i_xfer).
// Ports: clk/reset; i_xfer (word accepted), i_eop, i_type (type byte of current frame);
//        o_mismatch (high with the eop transfer when the frame length is wrong).
module sata_fis_len_checker
    import sata_fis_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_xfer,
    input  logic       i_eop,
    input  logic [7:0] i_type,
    output logic       o_mismatch
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [3:0] cnt_now;
    logic [3:0] exp_len;

    always_comb begin
        // Count including the current word; saturate so long Data FIS
        // frames never wrap back into the "too short" range.
        cnt_now    = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;
        exp_len    = fis_len(i_type);
        cnt_d      = cnt_q;
        o_mismatch = 1'b0;
        if (i_xfer) begin
            cnt_d = i_eop ? 4'd0 : cnt_now;
        end
        if (i_xfer && i_eop && (exp_len != 4'd0)) begin
            if (i_type == FIS_DATA) begin
                o_mismatch = (cnt_now < exp_len);
            end else begin
                o_mismatch = (cnt_now != exp_len);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sata_fis_rx_router.sv
// Routes link-layer RX frames by FIS type to register path, data path, DMA-Activate pulse or drop.
// Latency: 1 clk, every word incl. header passed through unmodified on the selected path.
// Backpressure: data path stalls via i_data_rdy; o_rdy = ~o_data_val | i_data_rdy gates all input.
// Ports: i_dat/i_val/i_eop/i_err from link layer, o_rdy upstream ready; o_reg_* register path
//        (no backpressure); o_data_* + i_data_rdy data path; o_dma_act, o_drop pulses; o_fis_type.
// Build option SATA_FIS_RX_LEN_CHECK_EN adds a frame length check and the o_len_err pulse output.
module sata_fis_rx_router
    import sata_fis_pkg::*;
(
    input  logic        reset,
    input  logic        clk,
    input  logic [31:0] i_dat,
    input  logic        i_val,
    input  logic        i_eop,
    input  logic        i_err,
    output logic        o_rdy,
    output logic [31:0] o_reg_dat,
    output logic        o_reg_val,
    output logic        o_reg_eop,
    output logic        o_reg_err,
    output logic [31:0] o_data_dat,
    output logic        o_data_val,
    output logic        o_data_eop,
    output logic        o_data_err,
    input  logic        i_data_rdy,
    output logic        o_dma_act,
    output logic        o_drop,
    output logic [7:0]  o_fis_type
`ifdef SATA_FIS_RX_LEN_CHECK_EN
    ,
    output logic        o_len_err
`endif
);

    route_t      route_q, route_d, cur_route;
    logic [31:0] reg_dat_q, reg_dat_d;
    logic        reg_val_q, reg_val_d;
    logic        reg_eop_q, reg_eop_d;
    logic        reg_err_q, reg_err_d;
    logic [31:0] data_dat_q, data_dat_d;
    logic        data_val_q, data_val_d;
    logic        data_eop_q, data_eop_d;
    logic        data_err_q, data_err_d;
    logic        dma_act_q, dma_act_d;
    logic        drop_q, drop_d;
    logic [7:0]  fis_type_q, fis_type_d;
    logic        xfer;
    logic        len_mis;
    logic        err_eff;

    assign o_rdy = ~data_val_q | i_data_rdy;
    assign xfer  = i_val & o_rdy;

`ifdef SATA_FIS_RX_LEN_CHECK_EN
    logic       len_err_q, len_err_d;
    logic [7:0] cur_type;

    // Header word carries its own type; later words use the latched one.
    assign cur_type = (route_q == RT_IDLE) ? i_dat[7:0] : fis_type_q;

    sata_fis_len_checker u_len_chk (
        .clk        (clk),
        .reset      (reset),
        .i_xfer     (xfer),
        .i_eop      (i_eop),
        .i_type     (cur_type),
        .o_mismatch (len_mis)
    );

    assign len_err_d = len_mis;
    assign o_len_err = len_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= len_err_d;
        end
    end
`else
    assign len_mis = 1'b0;
`endif

    // A length mismatch only exists on the eop word, so it folds into err there.
    assign err_eff = i_err | len_mis;

    always_comb begin
        // No SOF marker upstream: in IDLE every word is a header.
        cur_route = route_q;
        if (route_q == RT_IDLE) begin
            cur_route = fis_route(i_dat[7:0]);
        end

        route_d    = route_q;
        fis_type_d = fis_type_q;
        if (xfer) begin
            route_d = i_eop ? RT_IDLE : cur_route;
            if (route_q == RT_IDLE) begin
                fis_type_d = i_dat[7:0];
            end
        end

        // Register path: one-cycle valid per word, no hold.
        reg_val_d = xfer && (cur_route == RT_REG);
        reg_dat_d = reg_dat_q;
        reg_eop_d = 1'b0;
        reg_err_d = 1'b0;
        if (reg_val_d) begin
            reg_dat_d = i_dat;
            reg_eop_d = i_eop;
            reg_err_d = err_eff;
        end

        // Data path: hold the word until the consumer takes it.
        data_val_d = data_val_q;
        data_dat_d = data_dat_q;
        data_eop_d = data_eop_q;
        data_err_d = data_err_q;
        if (o_rdy) begin
            data_val_d = xfer && (cur_route == RT_DATA);
            data_eop_d = 1'b0;
            data_err_d = 1'b0;
            if (data_val_d) begin
                data_dat_d = i_dat;
                data_eop_d = i_eop;
                data_err_d = err_eff;
            end
        end

        dma_act_d = xfer && (cur_route == RT_DMAA) && i_eop && !err_eff;
        drop_d    = xfer && (cur_route == RT_DROP) && i_eop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            route_q    <= RT_IDLE;
            reg_dat_q  <= 32'd0;
            reg_val_q  <= 1'b0;
            reg_eop_q  <= 1'b0;
            reg_err_q  <= 1'b0;
            data_dat_q <= 32'd0;
            data_val_q <= 1'b0;
            data_eop_q <= 1'b0;
            data_err_q <= 1'b0;
            dma_act_q  <= 1'b0;
            drop_q     <= 1'b0;
            fis_type_q <= 8'd0;
        end else begin
            route_q    <= route_d;
            reg_dat_q  <= reg_dat_d;
            reg_val_q  <= reg_val_d;
            reg_eop_q  <= reg_eop_d;
            reg_err_q  <= reg_err_d;
            data_dat_q <= data_dat_d;
            data_val_q <= data_val_d;
            data_eop_q <= data_eop_d;
            data_err_q <= data_err_d;
            dma_act_q  <= dma_act_d;
            drop_q     <= drop_d;
            fis_type_q <= fis_type_d;
        end
    end

    assign o_reg_dat  = reg_dat_q;
    assign o_reg_val  = reg_val_q;
    assign o_reg_eop  = reg_eop_q;
    assign o_reg_err  = reg_err_q;
    assign o_data_dat = data_dat_q;
    assign o_data_val = data_val_q;
    assign o_data_eop = data_eop_q;
    assign o_data_err = data_err_q;
    assign o_dma_act  = dma_act_q;
    assign o_drop     = drop_q;
    assign o_fis_type = fis_type_q;

endmodule
